// File: rtl/wb_regfile_sb_if.sv
// Writeback/issue/read bundle between the pipeline front end and the
// writeback register file.
interface wb_regfile_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 3,
  parameter int SEL_W    = $clog2(NUM_SRC)
);
  logic                      wb_valid;
  logic [SEL_W-1:0]          wb_sel;
  logic [NUM_SRC*DATA_W-1:0] wb_src;
  logic                      wb_we;
  logic                      wb_setcc;
  logic [ADDR_W-1:0]         wb_dr;
  logic [DATA_W-1:0]         wb_data;
  logic                      iss_valid;
  logic [ADDR_W-1:0]         iss_dr;
  logic                      iss_ready;
  logic [ADDR_W-1:0]         sr1;
  logic [ADDR_W-1:0]         sr2;
  logic [DATA_W-1:0]         vsr1;
  logic [DATA_W-1:0]         vsr2;
  logic                      sr1_busy;
  logic                      sr2_busy;
  logic [2:0]                psr;
  logic                      wb_err;

  modport master (
    output wb_valid, wb_sel, wb_src, wb_we, wb_setcc, wb_dr,
    output iss_valid, iss_dr, sr1, sr2,
    input  wb_data, iss_ready, vsr1, vsr2, sr1_busy, sr2_busy, psr, wb_err
  );

  modport slave (
    input  wb_valid, wb_sel, wb_src, wb_we, wb_setcc, wb_dr,
    input  iss_valid, iss_dr, sr1, sr2,
    output wb_data, iss_ready, vsr1, vsr2, sr1_busy, sr2_busy, psr, wb_err
  );
endinterface

// File: rtl/wb_regfile_sb.sv
// Writeback stage: source select, register file with write-through bypass,
// NZP condition codes, per-register busy scoreboard and sticky error flag.
module wb_regfile_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 3,
  parameter int SEL_W    = $clog2(NUM_SRC)
) (
  input logic clk,
  input logic rst,
  wb_regfile_sb_if.slave bus
);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic [NUM_REGS-1:0]      busy;
  logic [2:0]               psr_q;
  logic                     err_q;
  logic signed [DATA_W-1:0] data;
  logic                     sel_ok;
  logic                     acc;
  logic                     clr;
  logic                     iss_set;

  function automatic logic [2:0] nzp(input logic signed [DATA_W-1:0] v);
    if (v < 0)       return 3'b100;
    else if (v == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  assign sel_ok = 32'(bus.wb_sel) < 32'(NUM_SRC);
  assign acc    = bus.wb_valid && sel_ok;
  assign clr    = acc && bus.wb_we;

  always_comb begin
    data = '0;
    for (int k = 0; k < NUM_SRC; k++)
      if (sel_ok && bus.wb_sel == SEL_W'(k))
        data = bus.wb_src[k*DATA_W +: DATA_W];
  end

  assign bus.wb_data = data;

  // A write landing on the issuing register frees it in the same cycle.
  assign bus.iss_ready = !busy[bus.iss_dr] || (clr && bus.wb_dr == bus.iss_dr);
  assign iss_set       = bus.iss_valid && bus.iss_ready;

  assign bus.vsr1     = (clr && bus.wb_dr == bus.sr1) ? data : regs[bus.sr1];
  assign bus.vsr2     = (clr && bus.wb_dr == bus.sr2) ? data : regs[bus.sr2];
  assign bus.sr1_busy = busy[bus.sr1] && !(clr && bus.wb_dr == bus.sr1);
  assign bus.sr2_busy = busy[bus.sr2] && !(clr && bus.wb_dr == bus.sr2);
  assign bus.psr      = psr_q;
  assign bus.wb_err   = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      busy  <= '0;
      psr_q <= 3'b010;
      err_q <= 1'b0;
    end else begin
      if (clr) regs[bus.wb_dr] <= data;
      if (acc && bus.wb_setcc) psr_q <= nzp(data);
      if ((bus.wb_valid && !sel_ok) || (clr && !busy[bus.wb_dr])) err_q <= 1'b1;
      // Set takes priority so a same-cycle reissue keeps the register busy.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (iss_set && bus.iss_dr == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (clr && bus.wb_dr == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Bench for wb_regfile_sb: reference model plus directed vectors on the
// default build and on a 32-bit / 16-register / 4-source build.
module tb_wb_regfile_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  wb_regfile_sb_if #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .NUM_SRC(3), .SEL_W(2)) b ();
  wb_regfile_sb_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_SRC(4), .SEL_W(2)) b2 ();

  wb_regfile_sb #(.DATA_W(16), .NUM_REGS(8), .ADDR_W(3), .NUM_SRC(3), .SEL_W(2))
    dut (.clk(clk), .rst(rst), .bus(b));
  wb_regfile_sb #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .NUM_SRC(4), .SEL_W(2))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model of the default build
  logic [15:0] m_regs [8];
  bit          m_busy [8];
  logic [2:0]  m_psr;
  bit          m_err;

  function automatic bit e_ok();
    return b.wb_valid && (b.wb_sel < 3);
  endfunction

  function automatic logic [15:0] e_data();
    if (b.wb_sel < 3) return 16'(b.wb_src >> (16 * b.wb_sel));
    return 16'h0;
  endfunction

  function automatic bit e_clr();
    return e_ok() && b.wb_we;
  endfunction

  function automatic bit e_rdy();
    return !m_busy[b.iss_dr] || (e_clr() && b.wb_dr == b.iss_dr);
  endfunction

  function automatic logic [2:0] e_cc(input logic [15:0] d);
    if ($signed(d) < 0) return 3'b100;
    if (d == 16'h0)     return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] e_rd(input logic [2:0] a);
    return (e_clr() && b.wb_dr == a) ? e_data() : m_regs[a];
  endfunction

  function automatic bit e_busy(input logic [2:0] a);
    return m_busy[a] && !(e_clr() && b.wb_dr == a);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        m_regs[i] <= 16'h0;
        m_busy[i] <= 1'b0;
      end
      m_psr <= 3'b010;
      m_err <= 1'b0;
    end else begin
      if (e_clr()) m_regs[b.wb_dr] <= e_data();
      if (e_ok() && b.wb_setcc) m_psr <= e_cc(e_data());
      if ((b.wb_valid && !e_ok()) || (e_clr() && !m_busy[b.wb_dr])) m_err <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        if (b.iss_valid && e_rdy() && b.iss_dr == 3'(i)) m_busy[i] <= 1'b1;
        else if (e_clr() && b.wb_dr == 3'(i))            m_busy[i] <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cmp_wb_data", 64'(b.wb_data), 64'(e_data()));
      chk("cmp_vsr1", 64'(b.vsr1), 64'(e_rd(b.sr1)));
      chk("cmp_vsr2", 64'(b.vsr2), 64'(e_rd(b.sr2)));
      chk("cmp_sr1_busy", 64'(b.sr1_busy), 64'(e_busy(b.sr1)));
      chk("cmp_sr2_busy", 64'(b.sr2_busy), 64'(e_busy(b.sr2)));
      chk("cmp_iss_ready", 64'(b.iss_ready), 64'(e_rdy()));
      chk("cmp_psr", 64'(b.psr), 64'(m_psr));
      chk("cmp_wb_err", 64'(b.wb_err), 64'(m_err));
    end
  end

  task automatic idle();
    b.wb_valid = 0; b.wb_sel = 0; b.wb_src = '0; b.wb_we = 0; b.wb_setcc = 0;
    b.wb_dr = 0; b.iss_valid = 0; b.iss_dr = 0; b.sr1 = 0; b.sr2 = 0;
    b2.wb_valid = 0; b2.wb_sel = 0; b2.wb_src = '0; b2.wb_we = 0; b2.wb_setcc = 0;
    b2.wb_dr = 0; b2.iss_valid = 0; b2.iss_dr = 0; b2.sr1 = 0; b2.sr2 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wb(input logic [1:0] sel, input logic [2:0] dr, input bit we, input bit cc,
                    input logic [47:0] src);
    b.wb_valid = 1; b.wb_sel = sel; b.wb_dr = dr; b.wb_we = we; b.wb_setcc = cc;
    b.wb_src = src;
  endtask

  task automatic issue(input logic [2:0] dr);
    b.iss_valid = 1; b.iss_dr = dr;
  endtask

  initial begin
    idle();
    rst = 1;
    @(posedge clk); @(posedge clk);
    #1 rst = 0;

    // Reset state: every register reads zero, nothing busy
    for (int r = 0; r < 8; r++) begin
      b.sr1 = 3'(r); b.iss_dr = 3'(r);
      #1;
      chk("rst_vsr1", 64'(b.vsr1), 64'h0);
      chk("rst_sr1_busy", 64'(b.sr1_busy), 64'h0);
      chk("rst_iss_ready", 64'(b.iss_ready), 64'h1);
    end
    chk("rst_psr", 64'(b.psr), 64'h2);
    chk("rst_wb_err", 64'(b.wb_err), 64'h0);
    tick();

    // Issue r3, then write back 0x8001 from the ALU with setcc
    issue(3);
    tick();
    b.sr1 = 3; #1;
    chk("iss_r3_busy", 64'(b.sr1_busy), 64'h1);
    tick();
    wb(0, 3, 1, 1, {16'h1234, 16'h0042, 16'h8001}); b.sr1 = 3; #1;
    chk("wb_r3_data", 64'(b.wb_data), 64'h8001);
    chk("wb_r3_bypass", 64'(b.vsr1), 64'h8001);
    chk("wb_r3_notbusy", 64'(b.sr1_busy), 64'h0);
    tick();
    b.sr1 = 3; #1;
    chk("r3_value", 64'(b.vsr1), 64'h8001);
    chk("r3_psr_neg", 64'(b.psr), 64'h4);
    chk("r3_busy_clr", 64'(b.sr1_busy), 64'h0);
    chk("r3_no_err", 64'(b.wb_err), 64'h0);
    tick();

    // Bypass from the memory source onto r5
    issue(5);
    tick();
    b.sr1 = 5; #1;
    chk("r5_busy", 64'(b.sr1_busy), 64'h1);
    wb(1, 5, 1, 0, {16'h1234, 16'h0042, 16'h8001}); #1;
    chk("r5_bypass", 64'(b.vsr1), 64'h0042);
    chk("r5_bypass_busy", 64'(b.sr1_busy), 64'h0);
    tick();
    b.sr1 = 5; b.sr2 = 3; #1;
    chk("r5_value", 64'(b.vsr1), 64'h0042);
    chk("r5_psr_hold", 64'(b.psr), 64'h4);
    chk("r3_port2", 64'(b.vsr2), 64'h8001);
    tick();

    // WAW stall, then same-cycle clear and reissue of r2
    issue(2);
    tick();
    issue(2); #1;
    chk("waw_stall", 64'(b.iss_ready), 64'h0);
    tick();
    issue(2);
    wb(2, 2, 1, 0, {16'h1234, 16'h0042, 16'h8001}); #1;
    chk("waw_clr_ready", 64'(b.iss_ready), 64'h1);
    tick();
    b.sr2 = 2; #1;
    chk("r2_value", 64'(b.vsr2), 64'h1234);
    chk("r2_still_busy", 64'(b.sr2_busy), 64'h1);
    chk("r2_no_err", 64'(b.wb_err), 64'h0);
    wb(0, 2, 1, 1, {16'h1234, 16'h0042, 16'h0000});
    tick();
    b.sr2 = 2; #1;
    chk("r2_zero", 64'(b.vsr2), 64'h0);
    chk("r2_psr_zero", 64'(b.psr), 64'h2);
    chk("r2_freed", 64'(b.sr2_busy), 64'h0);
    tick();

    // Invalid source select
    issue(1);
    tick();
    wb(3, 1, 1, 1, {16'h1234, 16'h0042, 16'h8001}); #1;
    chk("bad_sel_data", 64'(b.wb_data), 64'h0);
    tick();
    b.sr1 = 1; #1;
    chk("bad_sel_nowrite", 64'(b.vsr1), 64'h0);
    chk("bad_sel_psr", 64'(b.psr), 64'h2);
    chk("bad_sel_busy", 64'(b.sr1_busy), 64'h1);
    chk("bad_sel_err", 64'(b.wb_err), 64'h1);
    tick(); tick();
    #1 chk("err_sticky", 64'(b.wb_err), 64'h1);

    // Reset clears the flag; an unissued write to r7 sets it again
    rst = 1;
    tick();
    rst = 0; #1;
    chk("err_rst", 64'(b.wb_err), 64'h0);
    wb(0, 7, 1, 1, {16'h0000, 16'h0000, 16'h7FFF});
    tick();
    b.sr1 = 7; #1;
    chk("r7_value", 64'(b.vsr1), 64'h7FFF);
    chk("r7_err", 64'(b.wb_err), 64'h1);
    chk("r7_psr_pos", 64'(b.psr), 64'h1);
    tick();

    // Wide build: 32-bit data, 16 registers, 4 sources
    b2.iss_valid = 1; b2.iss_dr = 15;
    tick();
    b2.wb_valid = 1; b2.wb_sel = 1; b2.wb_dr = 15; b2.wb_we = 1;
    b2.wb_src = {32'h0, 32'h0, 32'hCAFE0001, 32'h0};
    b2.iss_valid = 1; b2.iss_dr = 15;
    tick();
    b2.sr1 = 15; #1;
    chk("w_r15_first", 64'(b2.vsr1), 64'hCAFE0001);
    chk("w_r15_busy", 64'(b2.sr1_busy), 64'h1);
    b2.wb_valid = 1; b2.wb_sel = 3; b2.wb_dr = 15; b2.wb_we = 1; b2.wb_setcc = 1;
    b2.wb_src = {32'h0, 32'h11111111, 32'h22222222, 32'h33333333};
    tick();
    b2.sr1 = 15; #1;
    chk("w_r15_zero", 64'(b2.vsr1), 64'h0);
    chk("w_psr_zero", 64'(b2.psr), 64'h2);
    chk("w_r15_free", 64'(b2.sr1_busy), 64'h0);
    chk("w_no_err", 64'(b2.wb_err), 64'h0);
    b2.wb_valid = 1; b2.wb_sel = 0; b2.wb_we = 0; b2.wb_setcc = 1;
    b2.wb_src = {32'h0, 32'h0, 32'h0, 32'h7FFFFFFF}; #1;
    chk("w_data_max", 64'(b2.wb_data), 64'h7FFFFFFF);
    tick();
    #1 chk("w_psr_pos", 64'(b2.psr), 64'h1);
    chk("w_ccnly_err", 64'(b2.wb_err), 64'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Parametrised next-generation writeback stage for the LC3 pipeline.
- Selects one of NUM_SRC result buses, writes it into a NUM_REGS x DATA_W register file, and updates the signed NZP condition codes.
- Adds a per-register busy scoreboard (set at issue, cleared at writeback), write-through bypass to the two read ports, and a sticky protocol-error flag.
- Sits between execute/memory and decode; decode uses the busy outputs to stall on hazards.

Parameters:
- DATA_W, 16, data width of registers and sources.
- NUM_REGS, 8, number of architectural registers (>=2).
- ADDR_W, $clog2(NUM_REGS), register index width.
- NUM_SRC, 3, number of writeback sources (0=alu, 1=mem, 2=pc by default).
- SEL_W, $clog2(NUM_SRC), source-select width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  writeback request this cycle.
- wb_sel  in  SEL_W  source index into wb_src.
- wb_src  in  NUM_SRC*DATA_W  packed sources; source k is bits [k*DATA_W +: DATA_W].
- wb_we  in  1  write wb_dr (0 = CC-only or no-op).
- wb_setcc  in  1  update psr from the selected data.
- wb_dr  in  ADDR_W  destination register.
- wb_data  out  DATA_W  selected source, combinational; 0 when wb_sel is invalid.
- iss_valid  in  1  decode issues an instruction writing iss_dr.
- iss_dr  in  ADDR_W  destination of the issuing instruction.
- iss_ready  out  1  issue accepted this cycle.
- sr1, sr2  in  ADDR_W  read addresses.
- vsr1, vsr2  out  DATA_W  read data, with bypass.
- sr1_busy, sr2_busy  out  1  source has a pending write.
- psr  out  3  {N,Z,P}.
- wb_err  out  1  sticky protocol error.

Behaviour:
- Reset, while rst is high at an edge:
  - All registers = 0 and busy[] = 0.
  - psr = 3'b010 (Z); wb_err = 0.
  - rst overrides any simultaneous wb or issue; nothing is written.
- Write acceptance: a write is accepted when wb_valid && wb_sel < NUM_SRC.
  - wb_we=1: regs[wb_dr] <= wb_data at the next edge. Latency 1 cycle to architectural state, 0 cycles through bypass.
  - wb_setcc=1: psr <= 3'b100 if wb_data[DATA_W-1]=1; 3'b010 if wb_data==0; else 3'b001. Signed two's-complement compare.
  - Otherwise psr holds. wb_setcc with wb_we=0 still updates psr.
- Invalid select: wb_valid && wb_sel >= NUM_SRC means no write, no psr change, no busy change, and wb_err <= 1.
- Bypass: if (wb_valid && wb_we && valid sel && wb_dr==srN), vsrN = wb_data. Otherwise vsrN = regs[srN].
- Scoreboard:
  - clr = accepted write with wb_we=1 clears busy[wb_dr].
  - Issue: iss_ready = !busy[iss_dr] || (clr && wb_dr==iss_dr). WAW hazards stall.
  - iss_valid && iss_ready sets busy[iss_dr].
  - Same-cycle clear and set on the same register: the set wins, and busy stays 1.
- srN_busy = busy[srN] && !(clr && wb_dr==srN). A register being written this cycle reads as not busy, because its value is bypassed.
- Write to a register whose busy=0 (no matching issue): the write still occurs and wb_err <= 1.
- wb_err clears only on rst.
- wb_valid=0: wb_we, wb_setcc, wb_dr and wb_sel are don't-care; no state change from the writeback side.
- No output is driven X; wb_data is 0 for an invalid sel.

Test Plan:
- Reset: rst=1 for 2 cycles, then read all registers -> every vsr1 = 0, psr = 3'b010, iss_ready = 1, all busy = 0, wb_err = 0.
- Issue then writeback:
  - Issue dr=3, then wb_sel=0, alu=16'h8001, we=1, setcc=1 -> psr = 3'b100 next cycle.
  - regs[3] = 16'h8001; busy[3] = 0; wb_err stays 0.
- Bypass/busy:
  - With busy[5] set, sr1=5 reads sr1_busy = 1.
  - Cycle with wb dr=5, sel=1, mem=16'h0042 -> same cycle vsr1 = 16'h0042 and sr1_busy = 0.
  - Next cycle vsr1 = 16'h0042 from the register file.
- WAW and simultaneous events:
  - busy[2]=1 and iss_dr=2 with no wb -> iss_ready = 0.
  - Same cycle wb dr=2 with iss_dr=2 -> iss_ready = 1, write occurs, busy[2] remains 1.
- Errors:
  - wb_sel=3 with NUM_SRC=3 -> no write, psr unchanged, wb_err = 1 and stays 1 until rst.
  - Write to non-busy r7 -> r7 written, wb_err = 1.
- Parametrised build: DATA_W=32, NUM_REGS=16, NUM_SRC=4.
  - Write 0 to r15 via sel=3 with setcc=1 -> psr = 3'b010, regs[15] = 0.
  - wb_data 32'h7FFFFFFF with setcc=1 -> psr = 3'b001.
